scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Registered channel-scan controller that sits directly upstream of the 3:8 enable-decoder stage. It drives the decoder's 3-bit select and enable inputs. It steps through the channels enabled in a mask, holding each channel for a programmable dwell time and inserting a blanking gap (enable low) between channels. It supports continuous and single-frame modes, and is used for display-digit and row multiplexing.

## Interface
- `BLANK_CYCLES`, default 2: cycles with `sel_en` low between channels; legal range 1..15.
- `DIV_W`, default 16: width of the dwell divider.
- `clk` in 1: the block's only clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled each cycle; begins a scan when in IDLE.
- `stop` in 1: aborts the scan; returns to IDLE on the next edge.
- `single` in 1: 1 = one frame then IDLE; 0 = continuous. Sampled at start.
- `mask` in 8: channel enables; bit i enables channel i.
- `div_val` in DIV_W: dwell length in cycles; 0 is treated as 1.
- `sel` out 3: channel index to the decoder's `data_in`.
- `sel_en` out 1: decoder enable.
- `busy` out 1: high in ACTIVE and BLANK.
- `frame_done` out 1: one-cycle pulse when a frame completes.

## Operation
- All outputs are registered. Reset values: `sel`=0, `sel_en`=0, `busy`=0, `frame_done`=0, state=IDLE, counters=0.
- **IDLE**
  - `start`=1 and `mask`≠0: go to ACTIVE.
    - `sel` = lowest set bit of `mask`.
    - Load the dwell counter with max(`div_val`,1)−1.
    - Latch `single`.
  - `start` with `mask`=0 is ignored.
- **ACTIVE**
  - `sel_en`=1; the dwell counter decrements each cycle.
  - When the count is 0: go to BLANK, load the blank counter with BLANK_CYCLES−1, and drop `sel_en`.
- **BLANK**
  - `sel_en`=0 and `sel` is held; the blank counter decrements.
  - When the count is 0, find the next channel by searching `mask` upward from `sel`+1 with wrap 7→0. `mask` is sampled on this cycle.
  - Wrap occurs when the next index ≤ current `sel`; this includes the case where the only enabled channel is itself. On wrap, pulse `frame_done`.
  - Wrap and latched single=1: go to IDLE; `sel` keeps its last value.
  - Otherwise: go to ACTIVE with the new `sel`, reloading the dwell counter from the current `div_val`.
  - Sampled `mask`=0: go to IDLE with no `frame_done` pulse.
- **Priority**: `rst` > `stop` > all else.
  - `stop` in any state: IDLE next cycle, `sel_en`=0, no `frame_done`.
  - `start` while busy is ignored.
- `div_val` is sampled only on ACTIVE entry; changes mid-dwell have no effect until the next channel.
- `sel_en` is never high during a `sel` change: `sel` changes only on the BLANK→ACTIVE or IDLE→ACTIVE edge.

## Timing
- Latency:
  - `start` sampled at edge N → `sel_en`=1 and `busy`=1 after edge N.
  - `stop` or `rst` sampled at edge N → `sel_en`=0 after edge N.
- Per-channel period is max(`div_val`,1) + BLANK_CYCLES cycles.
  - Frame length = popcount(`mask`) × that period.
- `frame_done` is high for exactly one cycle, coincident with the first cycle of the next ACTIVE, or the first IDLE cycle in single mode.
- Back-to-back frames in continuous mode have no extra gap beyond BLANK_CYCLES.

## Structure
- Package `scan_pkg` holds:
  - the state enum {IDLE, ACTIVE, BLANK};
  - `NUM_CH`=8 and `SEL_W`=3.
- One combinational sub-module, `scan_next_ch`:
  - inputs: `mask`[7:0] and current `sel`[2:0];
  - outputs: next index, a `wrap` flag, and a `none` flag (mask=0);
  - implementation: rotate-and-priority-encode.
- The top level holds the FSM, the dwell counter (DIV_W bits), and the blank counter (4 bits).
- The decoder stage connects as `sel`→`data_in` and `sel_en`→`en`.

## Test plan
- Reset and basic frame:
  - Stimulus: `rst` for 2 cycles, then `mask`=8'hFF, `div_val`=3, `single`=1, `start` pulse.
  - Response: `sel` steps 0..7; each channel has 3 cycles `sel_en`=1 then 2 cycles 0; `frame_done` pulses once at cycle 40; `busy` falls at the same time.
- Sparse mask with wrap:
  - Stimulus: `mask`=8'b1000_0101, `single`=0, `div_val`=1.
  - Response: `sel` sequence 0,2,7,0,2,…; `frame_done` at each 7→0 transition, every 9 cycles.
- `div_val`=0 and a single-bit mask:
  - Stimulus: `mask`=8'h10, `div_val`=0, continuous.
  - Response: `sel`=4 throughout; `sel_en` pattern 1,0,0 repeating; `frame_done` every 3 cycles.
- Mid-operation stop and restart:
  - Stimulus: `stop` asserted during ACTIVE on channel 3, then `start` 2 cycles later.
  - Response: `sel_en`=0 next cycle, no `frame_done`; restart begins at the lowest mask bit.
- Mask cleared mid-scan:
  - Stimulus: `mask` set to 0 during BLANK.
  - Response: IDLE after the blank, `busy`=0, no `frame_done`.
  - Stimulus: `start` with `mask`=0.
  - Response: remains IDLE.
- Reset mid-operation:
  - Stimulus: `rst` during ACTIVE.
  - Response: all outputs 0 after the edge.
  - Stimulus: `start` and `stop` in the same cycle.
  - Response: stays IDLE.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// Shared types and sizing for the channel-scan sequencer.
package scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan sequencer and whoever drives it.
// Inputs are level signals sampled on every rising clk edge; there is no
// valid/ready pair, and start/stop take effect on the edge that samples them.
interface scan_sequencer_if
  import scan_pkg::*;
#(
  parameter int DIV_W = 16
);

  logic              start;
  logic              stop;
  logic              single;
  logic [NUM_CH-1:0] mask;
  logic [DIV_W-1:0]  div_val;
  logic [SEL_W-1:0]  sel;
  logic              sel_en;
  logic              busy;
  logic              frame_done;
  scan_state_t       state;

  modport master (
    output start, stop, single, mask, div_val,
    input  sel, sel_en, busy, frame_done, state
  );

  modport slave (
    input  start, stop, single, mask, div_val,
    output sel, sel_en, busy, frame_done, state
  );

endinterface

// File: rtl/scan_sequencer_next_ch.sv
// Next enabled channel after sel (wrapping 7->0), via rotate then
// lowest-bit priority encode.
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  sel,
  output logic [SEL_W-1:0]  next_sel,
  output logic              wrap,
  output logic              none
);

  logic [2*NUM_CH-1:0] doubled;
  logic [NUM_CH-1:0]   rot;
  logic [SEL_W:0]      shift;
  logic [SEL_W-1:0]    off;

  always_comb begin
    shift   = (SEL_W+1)'(sel) + (SEL_W+1)'(1);
    doubled = {mask, mask} >> shift;
    rot     = doubled[NUM_CH-1:0];
    off     = '0;
    // Descending loop so the lowest set bit is the one that sticks.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    next_sel = sel + SEL_W'(1) + off;
    wrap     = (next_sel <= sel);
    none     = (mask == '0);
  end

endmodule

// File: rtl/scan_sequencer.sv
// Channel-scan controller feeding a 3:8 enable decoder: dwell on each enabled
// channel, blank between channels, continuous or single-frame.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int BLANK_CYCLES = 2,
  parameter int DIV_W        = 16
) (
  input logic             clk,
  input logic             rst,
  scan_sequencer_if.slave bus
);

  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

  scan_state_t      state;
  logic [SEL_W-1:0] sel_q;
  logic             sel_en_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             single_q;
  logic [DIV_W-1:0] dwell_cnt;
  logic [3:0]       blank_cnt;

  logic [SEL_W-1:0] search_from;
  logic [SEL_W-1:0] next_sel;
  logic             next_wrap;
  logic             next_none;
  logic [DIV_W-1:0] dwell_load;

  // From IDLE, searching upward from channel 7 yields the lowest set bit.
  assign search_from = (state == IDLE) ? SEL_W'(NUM_CH - 1) : sel_q;
  assign dwell_load  = (bus.div_val == '0) ? '0 : bus.div_val - DIV_W'(1);

  scan_next_ch u_next_ch (
    .mask     (bus.mask),
    .sel      (search_from),
    .next_sel (next_sel),
    .wrap     (next_wrap),
    .none     (next_none)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel_q        <= '0;
      sel_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      single_q     <= 1'b0;
      dwell_cnt    <= '0;
      blank_cnt    <= '0;
    end else if (bus.stop) begin
      state        <= IDLE;
      sel_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !next_none) begin
            state     <= ACTIVE;
            sel_q     <= next_sel;
            sel_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            single_q  <= bus.single;
            dwell_cnt <= dwell_load;
          end
        end
        ACTIVE: begin
          if (dwell_cnt == '0) begin
            state     <= BLANK;
            sel_en_q  <= 1'b0;
            blank_cnt <= BLANK_LOAD;
          end else begin
            dwell_cnt <= dwell_cnt - DIV_W'(1);
          end
        end
        BLANK: begin
          if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 4'd1;
          end else if (next_none) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (next_wrap && single_q) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end else begin
            // sel only moves here, while sel_en is still low.
            state        <= ACTIVE;
            sel_q        <= next_sel;
            sel_en_q     <= 1'b1;
            dwell_cnt    <= dwell_load;
            frame_done_q <= next_wrap;
          end
        end
        default: begin
          state    <= IDLE;
          sel_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_en     = sel_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: frame timing, wrap, dwell edge cases,
// stop/reset/mask-clear behaviour.
module tb_scan_sequencer;
  import scan_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  scan_sequencer_if #(.DIV_W(16)) bus ();

  scan_sequencer #(.BLANK_CYCLES(2), .DIV_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.single  = 1'b0;
    bus.mask    = '0;
    bus.div_val = '0;
  endtask

  task automatic stop_scan();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
    checks++;
    if (obs !== 6'b000_0_0_0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL reset: outputs=%b state=%0d, expected 000000 state=0", obs, bus.state);
    end
  endtask

  task automatic test_basic_frame();
    logic [5:0] obs, exp;
    bus.mask = 8'hFF; bus.div_val = 16'd3; bus.single = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      exp = {3'(k / 5), (k % 5) < 3, 1'b1, 1'b0};
      obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic_frame cycle %0d: {sel,en,busy,fd}=%b expected %b", k, obs, exp);
      end
      tick();
    end
    obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
    checks++;
    if (obs !== 6'b111_0_0_1 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL basic_frame end: %b state=%0d expected 111001 state=0", obs, bus.state);
    end
    tick();
    checks++;
    if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_frame pulse_width: fd=%b busy=%b expected 0 0", bus.frame_done, bus.busy);
    end
  endtask

  task automatic test_sparse_wrap();
    logic [5:0] obs, exp;
    logic [2:0] seq_tbl [3];
    seq_tbl = '{3'd0, 3'd2, 3'd7};
    bus.mask = 8'b1000_0101; bus.div_val = 16'd1; bus.single = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 27; k++) begin
      exp = {seq_tbl[(k / 3) % 3], (k % 3) == 0, 1'b1, (k % 9) == 0 && k != 0};
      obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sparse_wrap cycle %0d: {sel,en,busy,fd}=%b expected %b", k, obs, exp);
      end
      tick();
    end
    stop_scan();
  endtask

  task automatic test_div_zero_single_bit();
    logic [5:0] obs, exp;
    bus.mask = 8'h10; bus.div_val = 16'd0; bus.single = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      exp = {3'd4, (k % 3) == 0, 1'b1, (k % 3) == 0 && k != 0};
      obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL div_zero cycle %0d: {sel,en,busy,fd}=%b expected %b", k, obs, exp);
      end
      tick();
    end
    stop_scan();
  endtask

  task automatic test_div_sample();
    logic [5:0] obs, exp;
    logic [9:0] en_pat, sel1_pat;
    en_pat   = 10'b10_0100_1111;
    sel1_pat = 10'b01_1100_0000;
    bus.mask = 8'h03; bus.div_val = 16'd4; bus.single = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) bus.div_val = 16'd1;
      exp = {2'b00, sel1_pat[k], en_pat[k], 1'b1, k == 9};
      obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL div_sample cycle %0d: {sel,en,busy,fd}=%b expected %b", k, obs, exp);
      end
      tick();
    end
    stop_scan();
  endtask

  task automatic test_stop_restart();
    logic [5:0] obs;
    bus.mask = 8'b0010_1010; bus.div_val = 16'd4; bus.single = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    checks++;
    if (bus.sel !== 3'd3 || bus.sel_en !== 1'b1) begin
      errors++;
      $display("FAIL stop_setup: sel=%0d en=%b expected sel=3 en=1", bus.sel, bus.sel_en);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
    checks++;
    if (obs[2:0] !== 3'b000 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL stop: {sel,en,busy,fd}=%b state=%0d expected en/busy/fd=0 state=0", obs, bus.state);
    end
    tick();
    checks++;
    if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.sel_en !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold: fd=%b busy=%b en=%b expected 0 0 0", bus.frame_done, bus.busy, bus.sel_en);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
    checks++;
    if (obs !== 6'b001_1_1_0) begin
      errors++;
      $display("FAIL restart: {sel,en,busy,fd}=%b expected 001110", obs);
    end
    stop_scan();
  endtask

  task automatic test_mask_clear();
    logic [5:0] obs;
    bus.mask = 8'h06; bus.div_val = 16'd2; bus.single = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.mask = 8'h00;
    tick();
    obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
    checks++;
    if (obs !== 6'b001_0_1_0 || bus.state !== BLANK) begin
      errors++;
      $display("FAIL mask_clear_blank: %b state=%0d expected 001010 state=2", obs, bus.state);
    end
    tick();
    obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
    checks++;
    if (obs !== 6'b001_0_0_0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL mask_clear_idle: %b state=%0d expected 001000 state=0", obs, bus.state);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.sel_en !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL start_mask_zero: busy=%b en=%b state=%0d expected 0 0 0", bus.busy, bus.sel_en, bus.state);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs;
    bus.mask = 8'hF0; bus.div_val = 16'd5; bus.single = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = {bus.sel, bus.sel_en, bus.busy, bus.frame_done};
    checks++;
    if (obs !== 6'b000_0_0_0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid: %b state=%0d expected 000000 state=0", obs, bus.state);
    end
    bus.mask = 8'hFF; bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.sel_en !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL start_stop_same: busy=%b en=%b state=%0d expected 0 0 0", bus.busy, bus.sel_en, bus.state);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL start_stop_after: busy=%b state=%0d expected 0 0", bus.busy, bus.state);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_frame();
    test_sparse_wrap();
    test_div_zero_single_bit();
    test_div_sample();
    test_stop_restart();
    test_mask_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
